// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32 subset: sequences fetch/decode/exec/mem/wb and counts retirements.
// Optional BNE decoding is enabled by defining MC_BNE_EN.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_rdy,
  input  logic        br_eq,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  imm_sel,
  output logic [1:0]  alu_sel,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  localparam logic [2:0] ST_START  = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11;
  localparam logic [1:0] WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_jal, is_jalr;
  logic       is_br, supported;
  logic [1:0] op_alu;
  logic [2:0] state_next;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register specifiers are datapath concerns; the controller never looks at them.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign is_r = (opcode == 7'b0110011) &&
                (((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
                 ((funct7 == 7'b0000000) && ((funct3 == 3'b111) || (funct3 == 3'b110))));
  assign is_i = (opcode == 7'b0010011) &&
                ((funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110));
  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
`ifdef MC_BNE_EN
  assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
`else
  assign is_bne  = 1'b0;
`endif
  assign is_jal  = (opcode == 7'b1101111);
  assign is_jalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign is_br   = is_beq | is_bne;
  assign supported = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr;

  always_comb begin
    case (funct3)
      3'b111:  op_alu = ALU_AND;
      3'b110:  op_alu = ALU_OR;
      3'b000:  op_alu = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      default: op_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    mdr_we   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    reg_we   = 1'b0;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    imm_sel  = IMM_I;
    alu_sel  = ALU_ADD;
    wb_sel   = WB_ALU;
    case (state)
      ST_START: state_next = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: state_next = supported ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (is_r || is_i) begin
          b_sel      = is_i;
          alu_sel    = op_alu;
          reg_we     = 1'b1;
          pc_we      = 1'b1;
          state_next = ST_FETCH;
        end else if (is_lw || is_sw) begin
          b_sel      = 1'b1;
          imm_sel    = is_sw ? IMM_S : IMM_I;
          state_next = ST_MEM;
        end else if (is_br) begin
          a_sel      = 1'b1;
          b_sel      = 1'b1;
          imm_sel    = IMM_B;
          pc_we      = 1'b1;
          pc_sel     = is_beq ? br_eq : !br_eq;
          state_next = ST_FETCH;
        end else if (is_jal || is_jalr) begin
          a_sel      = is_jal;
          b_sel      = 1'b1;
          imm_sel    = is_jal ? IMM_J : IMM_I;
          reg_we     = 1'b1;
          wb_sel     = WB_PC4;
          pc_we      = 1'b1;
          pc_sel     = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_TRAP;
        end
      end
      ST_MEM: begin
        // Address operands stay selected so the ALU result remains valid while memory waits.
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_sw;
        b_sel    = 1'b1;
        imm_sel  = is_sw ? IMM_S : IMM_I;
        if (mem_rdy) begin
          if (is_sw) begin
            pc_we      = 1'b1;
            state_next = ST_FETCH;
          end else begin
            mdr_we     = 1'b1;
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        wb_sel     = WB_MEM;
        pc_we      = 1'b1;
        state_next = ST_FETCH;
      end
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_START;
      illegal <= 1'b0;
      instret <= 32'd0;
    end else begin
      state <= state_next;
      if (state_next == ST_TRAP) illegal <= 1'b1;
      if (pc_we) instret <= instret + 32'd1;
    end
  end

endmodule
